// File: rtl/refill_arbiter.sv
`default_nettype none
// refill_arbiter: shares one AXI read-burst port between icache and dcache line refills.
// Define REFILL_ARB_RR_EN for round-robin tie-break; default is fixed dcache-over-icache priority.
module refill_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_data_valid,
  output logic              ic_last,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic              dc_data_valid,
  output logic              dc_last,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic              r_last,
  input  logic [DATA_W-1:0] r_data,
  output logic              burst_err
);

  localparam int OFFS_W = $clog2(BURST_LEN * DATA_W / 8);
  localparam int CNT_W  = $clog2(BURST_LEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              burst_err_q, burst_err_d;

  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic              beat;
  logic              cnt_max;
  logic              burst_end;

`ifdef REFILL_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  // rr_ptr holds the requester served last; a tie goes to the other one.
  always_comb begin
    win = dc_req;
    if (ic_req && dc_req) begin
      win = ~rr_ptr_q;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (burst_end) begin
      rr_ptr_d = gnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign win = dc_req;
`endif

  assign win_addr  = win ? dc_addr : ic_addr;
  assign beat      = (state_q == DATA) && r_valid;
  assign cnt_max   = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign burst_end = beat && (r_last || cnt_max);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          gnt_d      = win;
          addr_d     = {win_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
          beat_cnt_d = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (ar_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (burst_end) begin
          burst_err_d = (r_last != cnt_max);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      addr_q      <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign ar_valid      = (state_q == ADDR);
  assign ar_addr       = addr_q;
  assign ar_len        = 8'(BURST_LEN - 1);
  assign r_ready       = (state_q == DATA);
  assign ic_data_valid = beat && !gnt_q;
  assign dc_data_valid = beat && gnt_q;
  assign ic_last       = burst_end && !gnt_q;
  assign dc_last       = burst_end && gnt_q;
  assign burst_err     = burst_err_q;

  // Beat payload goes straight to the caches; line-offset bits are dropped by alignment.
  logic unused_inputs;
  assign unused_inputs = ^{r_data, ic_addr[OFFS_W-1:0], dc_addr[OFFS_W-1:0]};

endmodule
`default_nettype wire
